// File: rtl/morse_keyer_decoder.sv
// Morse keyer decoder: times marks and gaps of a synchronised key level, classifies
// dots/dashes, assembles letters and flags letter and word gaps.
module morse_keyer_decoder #(
  parameter int UNIT_CLKS  = 4,
  parameter int DASH_UNITS = 3,
  parameter int LGAP_UNITS = 3,
  parameter int WGAP_UNITS = 7,
  parameter int MAX_SYMS   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                b,
  output logic                dot,
  output logic                dash,
  output logic                lg,
  output logic                wg,
  output logic [MAX_SYMS-1:0] code_out,
  output logic [4:0]          code_len,
  output logic                err,
  output logic                busy
);

  localparam int WGAP_CLKS = WGAP_UNITS * UNIT_CLKS;
  localparam int CW        = $clog2(WGAP_CLKS + 1);

  localparam logic [CW-1:0] CNT_SAT  = CW'(WGAP_CLKS);
  localparam logic [CW-1:0] DASH_TH  = CW'(DASH_UNITS * UNIT_CLKS);
  localparam logic [CW-1:0] LGAP_TH  = CW'(LGAP_UNITS * UNIT_CLKS);
  // LGAP restarts the counter, so it only has to cover the rest of the word gap.
  localparam logic [CW-1:0] WREST_TH = CW'(WGAP_CLKS - LGAP_UNITS * UNIT_CLKS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [4:0]    MAX_LEN  = 5'(MAX_SYMS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MARK = 2'b01,
    ST_GAP  = 2'b10,
    ST_LGAP = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic [MAX_SYMS-1:0] code_q, code_d;
  logic [4:0]          len_q, len_d;
  logic [MAX_SYMS-1:0] code_out_q, code_out_d;
  logic [4:0]          code_len_q, code_len_d;
  logic                dot_q, dot_d;
  logic                dash_q, dash_d;
  logic                lg_q, lg_d;
  logic                wg_q, wg_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                sym_s;

  function automatic logic [MAX_SYMS-1:0] shift_in(input logic [MAX_SYMS-1:0] code,
                                                   input logic sym);
    logic [MAX_SYMS-1:0] r;
    r    = code << 1;
    r[0] = sym;
    return r;
  endfunction

  assign cnt_inc_s = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_ONE;
  assign sym_s     = (cnt_q >= DASH_TH);

  // Next-state, counter, letter assembly and pulse generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc_s;
    code_d     = code_q;
    len_d      = len_q;
    code_out_d = code_out_q;
    code_len_d = code_len_q;
    dot_d      = 1'b0;
    dash_d     = 1'b0;
    lg_d       = 1'b0;
    wg_d       = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (b) begin
          state_d = ST_MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_MARK: begin
        if (b) begin
          cnt_d = cnt_inc_s;
        end else begin
          dash_d  = sym_s;
          dot_d   = ~sym_s;
          state_d = ST_GAP;
          cnt_d   = CNT_ONE;
          if (len_q < MAX_LEN) begin
            code_d = shift_in(code_q, sym_s);
            len_d  = len_q + 5'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (b) begin
          state_d = ST_MARK;
          cnt_d   = CNT_ONE;
        end else if (cnt_inc_s == LGAP_TH) begin
          lg_d       = 1'b1;
          code_out_d = code_q;
          code_len_d = len_q;
          code_d     = '0;
          len_d      = 5'd0;
          state_d    = ST_LGAP;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_LGAP: begin
        if (b) begin
          state_d = ST_MARK;
          cnt_d   = CNT_ONE;
        end else if (cnt_inc_s == WREST_TH) begin
          wg_d    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, letter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      len_q      <= 5'd0;
      code_out_q <= '0;
      code_len_q <= 5'd0;
      dot_q      <= 1'b0;
      dash_q     <= 1'b0;
      lg_q       <= 1'b0;
      wg_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      len_q      <= len_d;
      code_out_q <= code_out_d;
      code_len_q <= code_len_d;
      dot_q      <= dot_d;
      dash_q     <= dash_d;
      lg_q       <= lg_d;
      wg_q       <= wg_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign dot      = dot_q;
  assign dash     = dash_q;
  assign lg       = lg_q;
  assign wg       = wg_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign code_out = code_out_q;
  assign code_len = code_len_q;

endmodule

// File: tb/tb_morse_keyer_decoder.sv
// Bench for morse_keyer_decoder: directed table, corner sequences and random keying
// checked every cycle against a run-length reference model.
module tb_morse_keyer_decoder;

  localparam int DASH_CLKS = 12;
  localparam int LG_CLKS   = 12;
  localparam int WG_CLKS   = 28;
  localparam int MAXS      = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b = 1'b0;
  logic       dot, dash, lg, wg, err, busy;
  logic [5:0] code_out;
  logic [4:0] code_len;

  int checks = 0;
  int errors = 0;

  morse_keyer_decoder dut (
    .clk(clk), .reset(reset), .b(b),
    .dot(dot), .dash(dash), .lg(lg), .wg(wg),
    .code_out(code_out), .code_len(code_len),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: run lengths of the key level and a queue of symbols.
  int         m_hi, m_lo;
  bit         m_active;
  bit         m_syms[$];
  logic       e_dot, e_dash, e_lg, e_wg, e_err, e_busy;
  logic [5:0] e_code;
  logic [4:0] e_len;

  function automatic void model_reset();
    m_hi = 0; m_lo = 0; m_active = 1'b0; m_syms.delete();
    e_dot = 1'b0; e_dash = 1'b0; e_lg = 1'b0; e_wg = 1'b0; e_err = 1'b0;
    e_busy = 1'b0; e_code = 6'd0; e_len = 5'd0;
  endfunction

  function automatic void model_step(input bit bv);
    bit sym;
    e_dot = 1'b0; e_dash = 1'b0; e_lg = 1'b0; e_wg = 1'b0; e_err = 1'b0;
    if (bv) begin
      m_hi++; m_lo = 0; m_active = 1'b1;
    end else if (m_hi > 0) begin
      sym = (m_hi >= DASH_CLKS);
      if (sym) e_dash = 1'b1; else e_dot = 1'b1;
      if (m_syms.size() < MAXS) m_syms.push_back(sym); else e_err = 1'b1;
      m_hi = 0; m_lo = 1;
    end else if (m_active) begin
      m_lo++;
      if (m_lo == LG_CLKS) begin
        e_lg = 1'b1;
        e_code = 6'd0;
        foreach (m_syms[i]) e_code = {e_code[4:0], m_syms[i]};
        e_len = 5'(m_syms.size());
        m_syms.delete();
      end else if (m_lo == WG_CLKS) begin
        e_wg = 1'b1;
        m_active = 1'b0;
      end
    end
    e_busy = m_active;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit bv);
    b = bv;
    @(posedge clk);
    model_step(bv);
    #1;
    chk("model", {15'd0, dot, dash, lg, wg, err, busy, code_out, code_len},
        {15'd0, e_dot, e_dash, e_lg, e_wg, e_err, e_busy, e_code, e_len});
  endtask

  task automatic steps(input bit bv, input int n);
    for (int i = 0; i < n; i++) step(bv);
  endtask

  // Asynchronous reset in mid-cycle; outputs must drop before any clock edge.
  task automatic async_reset(input bit b_after);
    #2 reset = 1'b1;
    #1;
    chk("reset_async", {24'd0, dot, dash, lg, wg, err, busy, code_out, code_len}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    b = b_after;
    reset = 1'b0;
  endtask

  typedef struct {
    int         h0;
    int         l0;
    int         h1;
    logic [5:0] code;
    logic [4:0] len;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{h0: 4,  l0: 4,  h1: 12, code: 6'b000001, len: 5'd2};
    tbl[1] = '{h0: 11, l0: 11, h1: 12, code: 6'b000001, len: 5'd2};
    tbl[2] = '{h0: 12, l0: 4,  h1: 4,  code: 6'b000010, len: 5'd2};
    tbl[3] = '{h0: 4,  l0: 0,  h1: 0,  code: 6'b000000, len: 5'd1};
    tbl[4] = '{h0: 40, l0: 0,  h1: 0,  code: 6'b000001, len: 5'd1};
    tbl[5] = '{h0: 1,  l0: 1,  h1: 1,  code: 6'b000000, len: 5'd2};

    model_reset();
    reset = 1'b1;
    b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", {24'd0, dot, dash, lg, wg, err, busy, code_out, code_len}, 32'd0);
    reset = 1'b0;
    steps(1'b0, 3);

    // Directed letters: classification, lg on the 12th low sample, wg on the 28th.
    for (int t = 0; t < 6; t++) begin
      steps(1'b1, tbl[t].h0);
      if (tbl[t].h1 > 0) begin
        steps(1'b0, tbl[t].l0);
        steps(1'b1, tbl[t].h1);
      end
      for (int k = 1; k <= WG_CLKS; k++) begin
        step(1'b0);
        if (k == 1)
          chk("last_sym", {30'd0, dot, dash}, tbl[t].code[0] ? 32'd1 : 32'd2);
        if (k == 11) chk("lg_early", {31'd0, lg}, 32'd0);
        if (k == LG_CLKS) begin
          chk("lg_pulse", {31'd0, lg}, 32'd1);
          chk("lg_code", {26'd0, code_out}, {26'd0, tbl[t].code});
          chk("lg_len", {27'd0, code_len}, {27'd0, tbl[t].len});
        end
        if (k == 13) chk("code_hold", {26'd0, code_out}, {26'd0, tbl[t].code});
        if (k == WG_CLKS) chk("wg_pulse", {31'd0, wg}, 32'd1);
      end
      step(1'b0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Seven dots: the seventh overflows the letter.
    for (int i = 0; i < 7; i++) begin
      steps(1'b1, 4);
      if (i < 6) steps(1'b0, 4);
    end
    for (int k = 1; k <= LG_CLKS; k++) begin
      step(1'b0);
      if (k == 1) chk("overflow_err", {30'd0, dot, err}, 32'd3);
      if (k == LG_CLKS) begin
        chk("overflow_len", {27'd0, code_len}, 32'd6);
        chk("overflow_code", {26'd0, code_out}, 32'd0);
      end
    end
    steps(1'b0, 17);

    // Key rises in the lg cycle: letter closes and that cycle starts a 12-sample dash.
    steps(1'b1, 4);
    steps(1'b0, LG_CLKS);
    chk("rise_lg", {31'd0, lg}, 32'd1);
    steps(1'b1, 12);
    step(1'b0);
    chk("rise_dash", {30'd0, dot, dash}, 32'd1);
    steps(1'b0, LG_CLKS - 1);
    chk("rise_lg2", {31'd0, lg}, 32'd1);
    chk("rise_code", {26'd0, code_out, 1'b0} | {27'd0, code_len}, {26'd1, 1'b0} | 32'd1);
    steps(1'b0, 17);

    // Reset mid-dash after three dots, released with the key up.
    for (int i = 0; i < 3; i++) begin
      steps(1'b1, 4);
      steps(1'b0, 4);
    end
    steps(1'b1, 8);
    async_reset(1'b0);
    steps(1'b0, 30);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);
    async_reset(1'b1);
    step(1'b1);
    chk("reset_mark_entry", {31'd0, busy}, 32'd1);
    steps(1'b1, 3);
    steps(1'b0, WG_CLKS + 1);

    // Random keying with occasional resets.
    for (int r = 0; r < 60; r++) begin
      steps(1'b1, $urandom_range(1, 20));
      if ($urandom_range(0, 9) == 0) async_reset(1'b0);
      steps(1'b0, $urandom_range(1, 32));
    end
    steps(1'b0, WG_CLKS + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer_decoder.md
MORSE_KEYER_DECODER -- requirements
Module: morse_keyer_decoder

Interface
REQ-001 Parameter UNIT_CLKS, default 4: clock cycles per Morse unit, >=1.
REQ-002 Parameter DASH_UNITS, default 3: minimum mark length in units classified as dash, >=2.
REQ-003 Parameter LGAP_UNITS, default 3: gap length in units that ends a letter, >=1.
REQ-004 Parameter WGAP_UNITS, default 7: gap length in units that ends a word, >LGAP_UNITS.
REQ-005 Parameter MAX_SYMS, default 6: symbols per letter, 1..16.
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port b, input, 1: key level, already synchronised; 1 = mark.
REQ-009 Port dot, output, 1: one-cycle pulse, dot symbol classified.
REQ-010 Port dash, output, 1: one-cycle pulse, dash symbol classified.
REQ-011 Port lg, output, 1: one-cycle pulse, letter gap detected; code_out and code_len valid.
REQ-012 Port wg, output, 1: one-cycle pulse, word gap detected.
REQ-013 Port code_out, output, MAX_SYMS: completed letter; bit 0 = last symbol; 1 = dash; unused upper bits 0.
REQ-014 Port code_len, output, 5: symbol count of code_out, 0..MAX_SYMS.
REQ-015 Port err, output, 1: one-cycle pulse, symbol dropped because the letter is full.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 States are IDLE, MARK, GAP and LGAP, with a registered 2-bit encoding; illegal codes go to IDLE.
REQ-018 Timing uses an internal cycle counter. It clears on every state change, saturates at WGAP_UNITS*UNIT_CLKS, and has width clog2(WGAP_UNITS*UNIT_CLKS+1); no external timer.
REQ-019 IDLE: b=1 -> MARK; the counter counts high samples, including the entry cycle.
REQ-020 MARK, b=0: mark length N = number of consecutive high samples.
 - N >= DASH_UNITS*UNIT_CLKS -> dash, otherwise dot.
 - dot or dash asserts in the cycle after the first low sample.
 - -> GAP.
REQ-021 On classification with len < MAX_SYMS, the symbol is shifted into bit 0 of the working code and len increments.
REQ-022 On classification with len == MAX_SYMS, the symbol is dropped: err pulses with dot/dash, and len and code are unchanged.
REQ-023 GAP:
 - b=1 before LGAP_UNITS*UNIT_CLKS consecutive low samples -> MARK (same letter).
 - On reaching that count, lg pulses in the next cycle, code_out/code_len load the working code, the working code and len clear, -> LGAP.
REQ-024 LGAP:
 - b=1 -> MARK (new letter).
 - When total consecutive low samples since the mark reach WGAP_UNITS*UNIT_CLKS, wg pulses in the next cycle, -> IDLE.
REQ-025 code_out/code_len hold their value until the next lg; they are stable while lg=1.
REQ-026 If b rises in the same cycle the letter-gap count is reached: lg fires, the letter closes, and the next state is MARK, counting that cycle as the first high sample.
REQ-027 dot, dash, lg and wg are registered and mutually exclusive; at most one is high per cycle. err only accompanies dot or dash.
REQ-028 Mark length saturation: marks longer than the counter range still classify as dash.

Reset
REQ-029 reset=1 asynchronously forces:
 - state IDLE
 - counter, working code and len to 0
 - code_out=0, code_len=0
 - dot=dash=lg=wg=err=busy=0
REQ-030 A reset mid-mark or mid-letter discards the partial letter with no pulses. After release with b=1, the block enters MARK on the first clock edge.

Verification (defaults: UNIT_CLKS=4, DASH=3, LGAP=3, WGAP=7, MAX_SYMS=6)
REQ-031 b high 4 cycles, then low -> dot=1 one cycle after the fall; after 12 low cycles, lg=1, code_out=0, code_len=1.
REQ-032 High 4, low 4, high 12, low 12 ('A') -> dot, dash, then lg with code_out=6'b000001, code_len=2.
REQ-033 After one dot, b low 28 cycles -> lg 12 cycles after the fall, wg 28 cycles after the fall, busy=0 afterwards.
REQ-034 Seven dots separated by 4-cycle gaps -> 7th dot pulses with err=1; lg gives code_len=6, code_out=0.
REQ-035 High 11 cycles -> dot; high 12 cycles -> dash. b rises exactly on the 12th low cycle -> lg and next state MARK.
REQ-036 reset asserted mid-dash with len=3 -> all outputs 0 immediately; released with b=0 -> IDLE, no pulses.
